// File: rtl/microseq_ctrl.sv
// Table-driven micro-sequencer: expands each opcode into a run of control-state codes,
// with a zero-flag alternate sequence, a fetch/load selector and a sticky halt.
module microseq_ctrl #(
  parameter int OP_W       = 6,
  parameter int STATE_W    = 6,
  parameter int MAX_STEPS  = 4,
  parameter int FETCH_OP   = 1,
  parameter int LOAD_OP    = 0,
  parameter int HALT_OP    = 57,
  parameter int NOP_STATE  = 56,
  parameter int HALT_STATE = 57,
  localparam int LEN_W     = $clog2(MAX_STEPS + 1),
  localparam int ENTRY_W   = 1 + 2 * (LEN_W + STATE_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [OP_W-1:0]    op_in,
  input  logic               z_in,
  input  logic               cfg_we,
  input  logic [OP_W-1:0]    cfg_addr,
  input  logic [ENTRY_W-1:0] cfg_data,
  output logic [STATE_W-1:0] sm_state,
  output logic [OP_W-1:0]    next_op,
  output logic               busy,
  output logic               seq_done,
  output logic               halted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_t;

  logic [ENTRY_W-1:0] seq_table [2**OP_W];

  seq_state_t         state_q;
  logic [LEN_W-1:0]   step_q;
  logic [LEN_W-1:0]   len_q;
  logic [STATE_W-1:0] base_q;
  logic [OP_W-1:0]    op_q;

  logic [ENTRY_W-1:0] entry;
  logic               use_alt;
  logic [LEN_W-1:0]   raw_len;
  logic [LEN_W-1:0]   eff_len;
  logic [STATE_W-1:0] eff_base;

  // Sequence table, writable at any time; the FSM latches what it needs at sampling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**OP_W; i++) begin
        seq_table[i] <= '0;
      end
    end else if (cfg_we) begin
      seq_table[cfg_addr] <= cfg_data;
    end
  end

  // Entry layout, LSB first: base, len, alt_base, alt_len, cond.
  always_comb begin
    entry    = seq_table[op_in];
    use_alt  = entry[ENTRY_W-1] & z_in;
    raw_len  = use_alt ? entry[2*STATE_W+LEN_W +: LEN_W] : entry[STATE_W +: LEN_W];
    eff_base = use_alt ? entry[STATE_W+LEN_W +: STATE_W] : entry[0 +: STATE_W];
    eff_len  = (raw_len > LEN_W'(MAX_STEPS)) ? LEN_W'(MAX_STEPS) : raw_len;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      step_q   <= '0;
      len_q    <= '0;
      base_q   <= '0;
      op_q     <= '0;
      sm_state <= STATE_W'(NOP_STATE);
      next_op  <= OP_W'(FETCH_OP);
      busy     <= 1'b0;
      seq_done <= 1'b0;
      halted   <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      if (start) begin
        case (state_q)
          IDLE: begin
            if (op_in == OP_W'(HALT_OP)) begin
              sm_state <= STATE_W'(HALT_STATE);
              next_op  <= OP_W'(HALT_OP);
              halted   <= 1'b1;
              state_q  <= HALT;
            end else if (eff_len == '0) begin
              sm_state <= STATE_W'(NOP_STATE);
              next_op  <= OP_W'(FETCH_OP);
            end else begin
              sm_state <= eff_base;
              base_q   <= eff_base;
              len_q    <= eff_len;
              op_q     <= op_in;
              // A one-step fetch is both first and last step; the load selector wins.
              if (op_in == OP_W'(FETCH_OP)) begin
                next_op <= OP_W'(LOAD_OP);
              end else if (eff_len == LEN_W'(1)) begin
                next_op <= OP_W'(FETCH_OP);
              end
              if (eff_len == LEN_W'(1)) begin
                seq_done <= 1'b1;
              end else begin
                state_q <= RUN;
                busy    <= 1'b1;
                step_q  <= LEN_W'(1);
              end
            end
          end
          RUN: begin
            sm_state <= base_q + STATE_W'(step_q);
            if (step_q == len_q - LEN_W'(1)) begin
              seq_done <= 1'b1;
              busy     <= 1'b0;
              step_q   <= '0;
              state_q  <= IDLE;
              if (op_q != OP_W'(FETCH_OP)) begin
                next_op <= OP_W'(FETCH_OP);
              end
            end else begin
              step_q <= step_q + LEN_W'(1);
            end
          end
          HALT: begin
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
